// File: rtl/acc_pkg.sv
// Shared definitions for the frame accumulator.
//   state_t    : controller states (IDLE, ADD_LO, ADD_HI, DONE)
//   half_width : derives the per-cycle adder width from the datapath width
package acc_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ADD_LO = 2'd1,
    ADD_HI = 2'd2,
    DONE   = 2'd3
  } state_t;

  // The datapath is processed as two equal halves, so the width must be even.
  function automatic int half_width(input int data_w);
    return data_w / 2;
  endfunction

endpackage

// File: rtl/add_half.sv
// Combinational half-width adder with carry in/out. The accumulator reuses a
// single instance for both the low and the high half of every sample.
//   a, b  in  W  operands
//   cin   in  1  carry in
//   sum   out W  a + b + cin, modulo 2^W
//   cout  out 1  carry out of the MSB
module add_half #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] full_s;

  assign full_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign sum    = full_s[W-1:0];
  assign cout   = full_s[W];

endmodule

// File: rtl/sum_frame_accumulator.sv
// Accumulates COUNT samples of DATA_W bits into one frame total, adding one
// half per cycle through a shared half-width adder (low half, then high half
// with the stored carry). The total and a sticky overflow flag are offered on
// a valid/ready output.
//   clk, reset          clock; synchronous active-high reset
//   in_valid/in_ready   sample handshake (ready only in IDLE)
//   in_data             sample
//   out_valid/out_ready frame handshake (valid only in DONE)
//   out_sum             frame total modulo 2^DATA_W
//   out_ovf             a carry left the MSB at some point in the frame
module sum_frame_accumulator
  import acc_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int COUNT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf
);

  localparam int HALF_W = half_width(DATA_W);
  localparam int CNT_W  = $clog2(COUNT + 1);

  state_t              state_r;
  state_t              state_s;
  logic [DATA_W-1:0]   acc_r;
  logic [DATA_W-1:0]   op_r;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic                ovf_r;
  logic                carry_r;
  logic                in_ready_r;
  logic                out_valid_r;

  logic [HALF_W-1:0]   add_a_s;
  logic [HALF_W-1:0]   add_b_s;
  logic                add_cin_s;
  logic [HALF_W-1:0]   add_sum_s;
  logic                add_cout_s;

  assign cnt_inc_s = cnt_r + CNT_W'(1'b1);

  // Select which half feeds the shared adder; the carry is only used on the
  // high half and only comes from the low half of the same sample.
  always_comb begin
    add_a_s   = acc_r[HALF_W-1:0];
    add_b_s   = op_r[HALF_W-1:0];
    add_cin_s = 1'b0;
    if (state_r == ADD_HI) begin
      add_a_s   = acc_r[DATA_W-1:HALF_W];
      add_b_s   = op_r[DATA_W-1:HALF_W];
      add_cin_s = carry_r;
    end else begin
      add_a_s   = acc_r[HALF_W-1:0];
      add_b_s   = op_r[HALF_W-1:0];
      add_cin_s = 1'b0;
    end
  end

  add_half #(
    .W (HALF_W)
  ) u_add_half (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state logic for the accept / add-low / add-high / present sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = ADD_LO;
        end else begin
          state_s = IDLE;
        end
      end
      ADD_LO: begin
        state_s = ADD_HI;
      end
      ADD_HI: begin
        if (cnt_inc_s == CNT_W'(COUNT)) begin
          state_s = DONE;
        end else begin
          state_s = IDLE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register plus handshake flags registered from the next state, so
  // they line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Datapath: operand capture, half-wise accumulation, sample count and the
  // sticky overflow; everything is cleared when a finished frame is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r   <= {DATA_W{1'b0}};
      op_r    <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      ovf_r   <= 1'b0;
      carry_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            op_r <= in_data;
          end
        end
        ADD_LO: begin
          acc_r[HALF_W-1:0] <= add_sum_s;
          carry_r           <= add_cout_s;
        end
        ADD_HI: begin
          acc_r[DATA_W-1:HALF_W] <= add_sum_s;
          ovf_r                  <= ovf_r | add_cout_s;
          cnt_r                  <= cnt_inc_s;
        end
        DONE: begin
          if (out_ready) begin
            acc_r   <= {DATA_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            ovf_r   <= 1'b0;
            carry_r <= 1'b0;
          end
        end
        default: begin
          acc_r <= acc_r;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_sum   = acc_r;
  assign out_ovf   = ovf_r;

endmodule
